truth_table_scanner: RTL and testbench

Sequential driver/collector placed directly upstream of the 4-input function unit (fu4x16). On a start pulse it sweeps the function unit's input through every code 0..2^WIDTH-1, one per clock. It samples the combinational function output for each code into a truth-table register and counts the ones. It signals completion with a one-cycle done pulse, giving the lab board a self-characterising function block.

---
 rtl/tts_pkg.sv | 15 +
 rtl/tts_index_counter.sv | 43 ++++
 rtl/truth_table_scanner.sv | 126 ++++++++++++
 tb/tb_truth_table_scanner.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/tts_pkg.sv
// Shared types and constants for the truth-table scanner and its index counter.
package tts_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } tts_state_e;

    localparam int TTS_WIDTH = 4;
    localparam int TTS_DEPTH = 16;

    // Truth table of the prime-detector function normally attached as fu4x16
    localparam logic [TTS_DEPTH-1:0] TTS_GOLDEN = 16'h28AC;

endpackage

// File: rtl/tts_index_counter.sv
// Loadable up-counter with clear, enable and terminal-count flag; drives the function unit code.
module tts_index_counter
    import tts_pkg::*;
#(
    parameter int WIDTH = TTS_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear wins over load, load wins over increment
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == {WIDTH{1'b1}});

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps an attached combinational function unit through all input codes and captures its truth table.
// Optional golden-table comparison is enabled by defining TTS_CHECK_EN.
module truth_table_scanner
    import tts_pkg::*;
#(
    parameter int                      WIDTH    = TTS_WIDTH,
    parameter logic [(2**WIDTH)-1:0]   EXPECTED = TTS_GOLDEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [WIDTH-1:0]      fu_in,
    input  logic                  fu_out,
    output logic                  busy,
    output logic                  done,
    output logic [(2**WIDTH)-1:0] table_out,
    output logic [WIDTH:0]        ones,
    output logic                  mismatch
);

    localparam int DEPTH = 2**WIDTH;

    tts_state_e       state_q, state_d;
    logic [DEPTH-1:0] table_q, table_d;
    logic [WIDTH:0]   ones_q, ones_d;
    logic             done_q, done_d;

    logic             cntClr;
    logic             cntEn;
    logic             lastCode;
    logic [WIDTH-1:0] code;

    tts_index_counter #(
        .WIDTH (WIDTH)
    ) u_index (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cntClr),
        .en_i       (cntEn),
        .load_i     (1'b0),
        .load_val_i ('0),
        .count_o    (code),
        .tc_o       (lastCode)
    );

    // The code on fu_in is sampled back through fu_out in the same cycle
    always_comb begin
        state_d = state_q;
        table_d = table_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        cntClr  = 1'b0;
        cntEn   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    table_d = '0;
                    ones_d  = '0;
                end
            end
            SCAN: begin
                table_d[code] = fu_out;
                ones_d        = ones_q + {{WIDTH{1'b0}}, fu_out};
                if (lastCode) begin
                    state_d = IDLE;
                    cntClr  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cntEn   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cntClr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            table_q <= '0;
            ones_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            table_q <= table_d;
            ones_q  <= ones_d;
            done_q  <= done_d;
        end
    end

    assign fu_in     = code;
    assign busy      = (state_q == SCAN);
    assign done      = done_q;
    assign table_out = table_q;
    assign ones      = ones_q;

`ifdef TTS_CHECK_EN
    logic mismatch_q, mismatch_d;

    // Verdict is registered alongside done and then held with the table
    always_comb begin
        mismatch_d = mismatch_q;
        if (state_q == IDLE && start) begin
            mismatch_d = 1'b0;
        end else if (state_q == SCAN && lastCode) begin
            mismatch_d = (table_d != EXPECTED);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner with a prime-detector or constant-one function model on fu_out.
module tb_truth_table_scanner;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  fuIn;
    logic        fuOut;
    logic        busy;
    logic        done;
    logic [15:0] tableOut;
    logic [4:0]  ones;
    logic        mismatch;

    logic [15:0] primeMask;
    logic        constOne;

    int vectorCount;
    int missCount;

`ifdef TTS_CHECK_EN
    localparam logic CONST_MIS = 1'b1;
`else
    localparam logic CONST_MIS = 1'b0;
`endif

    truth_table_scanner dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fu_in     (fuIn),
        .fu_out    (fuOut),
        .busy      (busy),
        .done      (done),
        .table_out (tableOut),
        .ones      (ones),
        .mismatch  (mismatch)
    );

    // Function unit model: primes below 16, or stuck at one
    assign fuOut = constOne ? 1'b1 : primeMask[fuIn];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
        end
    endtask

    // Launches one scan and follows it to its done pulse
    task automatic applyStimulus(input logic [15:0] expTable, input logic [4:0] expOnes,
                                 input logic expMis, input int reStartAt);
        int  cyc;
        bit  seen;
        cyc   = 0;
        seen  = 0;
        start = 1'b1;
        while (cyc < 40 && !seen) begin
            @(negedge clk);
            cyc++;
            start = (cyc == reStartAt);
            if (done) begin
                seen = 1;
            end else if (cyc <= 16) begin
                checkOutput("scanCode", 32'(fuIn), 32'(cyc - 1));
                checkOutput("scanBusy", 32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        checkOutput("doneLatency", 32'(cyc), 32'd17);
        checkOutput("doneBusy", 32'(busy), 32'd0);
        checkOutput("doneCode", 32'(fuIn), 32'd0);
        checkOutput("table", 32'(tableOut), 32'(expTable));
        checkOutput("ones", 32'(ones), 32'(expOnes));
        checkOutput("mismatch", 32'(mismatch), 32'(expMis));
        @(negedge clk);
        checkOutput("donePulseWidth", 32'(done), 32'd0);
        checkOutput("tableHold", 32'(tableOut), 32'(expTable));
        checkOutput("onesHold", 32'(ones), 32'(expOnes));
    endtask

    initial begin
        int doneCnt;
        int firstDone;
        int secondDone;

        vectorCount = 0;
        missCount   = 0;
        primeMask   = 16'h28AC;
        constOne    = 1'b0;
        rst         = 1'b1;
        start       = 1'b0;

        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset and idle");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idleCode", 32'(fuIn), 32'd0);
            checkOutput("idleBusy", 32'(busy), 32'd0);
            checkOutput("idleDone", 32'(done), 32'd0);
            checkOutput("idleTable", 32'(tableOut), 32'h0000);
            checkOutput("idleOnes", 32'(ones), 32'd0);
        end

        $display("[TB] prime function scan");
        applyStimulus(16'h28AC, 5'd6, 1'b0, 0);

        $display("[TB] constant-one scan");
        constOne = 1'b1;
        applyStimulus(16'hFFFF, 5'b10000, CONST_MIS, 0);
        constOne = 1'b0;

        $display("[TB] start re-asserted mid-scan");
        applyStimulus(16'h28AC, 5'd6, 1'b0, 5);
        doneCnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("noExtraDone", 32'(doneCnt), 32'd0);

        $display("[TB] reset mid-scan");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("preResetCode", 32'(fuIn), 32'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortCode", 32'(fuIn), 32'd0);
        checkOutput("abortTable", 32'(tableOut), 32'h0000);
        checkOutput("abortOnes", 32'(ones), 32'd0);
        doneCnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("abortNoDone", 32'(doneCnt), 32'd0);
        applyStimulus(16'h28AC, 5'd6, 1'b0, 0);

        $display("[TB] start held high");
        doneCnt    = 0;
        firstDone  = 0;
        secondDone = 0;
        start      = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done) begin
                doneCnt++;
                if (doneCnt == 1) firstDone = cyc;
                if (doneCnt == 2) secondDone = cyc;
                checkOutput("heldTable", 32'(tableOut), 32'h28AC);
                checkOutput("heldOnes", 32'(ones), 32'd6);
            end
        end
        start = 1'b0;
        checkOutput("heldDoneCount", 32'(doneCnt), 32'd2);
        checkOutput("heldFirstDone", 32'(firstDone), 32'd17);
        checkOutput("heldSecondDone", 32'(secondDone), 32'd34);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
